// File: rtl/cache_axi_pkg.sv
// Shared types and constants for the cache-side AXI read path.
// Holds read-type codes, FSM states, owner encoding and AR field mapping.
package cache_axi_pkg;

    localparam logic [2:0] RD_TYPE_BYTE = 3'b000;
    localparam logic [2:0] RD_TYPE_HALF = 3'b001;
    localparam logic [2:0] RD_TYPE_WORD = 3'b010;
    localparam logic [2:0] RD_TYPE_LINE = 3'b100;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        AR   = 2'd1,
        R    = 2'd2
    } rd_state_e;

    typedef enum logic {
        OWNER_I = 1'b0,
        OWNER_D = 1'b1
    } owner_e;

    // A line is a 4-beat burst; everything else is a single beat.
    function automatic logic [7:0] rd_arlen(input logic [2:0] t);
        return (t == RD_TYPE_LINE) ? 8'd3 : 8'd0;
    endfunction

    // 011 folds onto word; 1xx (line and reserved codes) are word-sized beats.
    function automatic logic [2:0] rd_arsize(input logic [2:0] t);
        if (t[2] || t[1]) begin
            return 3'd2;
        end
        return {2'b00, t[0]};
    endfunction

endpackage

// File: rtl/rd_grant2.sv
// Two-way grant for icache/dcache read requests plus the rr pointer.
// Ports: clk_i, rst_i (async, active-high), en_i (arbiter idle),
//   i_req_i, d_req_i requests, update_i accept handshake,
//   i_gnt_o, d_gnt_o combinational grants.
// Build option AXI_RD_ARB_RR_EN: round robin; otherwise dcache wins.
module rd_grant2
    import cache_axi_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic i_req_i,
    input  logic d_req_i,
    input  logic update_i,
    output logic i_gnt_o,
    output logic d_gnt_o
);

    owner_e win;

`ifdef AXI_RD_ARB_RR_EN
    // last_q holds the most recently granted owner; the other one
    // wins the next tie.
    owner_e last_q;
    owner_e last_d;

    always_comb begin
        if (i_req_i && d_req_i) begin
            win = (last_q == OWNER_I) ? OWNER_D : OWNER_I;
        end else begin
            win = d_req_i ? OWNER_D : OWNER_I;
        end
    end

    always_comb begin
        last_d = last_q;
        if (update_i) begin
            last_d = win;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_q <= OWNER_I;
        end else begin
            last_q <= last_d;
        end
    end
`else
    assign win = d_req_i ? OWNER_D : OWNER_I;

    logic unused_ok;
    assign unused_ok = ^{clk_i, rst_i, update_i};
`endif

    assign i_gnt_o = en_i && i_req_i && (win == OWNER_I);
    assign d_gnt_o = en_i && d_req_i && (win == OWNER_D);

endmodule

// File: rtl/axi_rd_arbiter.sv
// Shares one AXI AR/R channel between icache and dcache refill ports,
// one transaction outstanding. Ports: clock/reset, i_* and d_* cache
// request/return ports, AXI AR/R master ports, sticky burst_err.
// Build option AXI_RD_ARB_RR_EN selects round-robin arbitration.
module axi_rd_arbiter
    import cache_axi_pkg::*;
#(
    parameter int ID_WIDTH   = 4,
    parameter int DATA_WIDTH = 32,
    parameter int INST_ID    = 0,
    parameter int DATA_ID    = 1
) (
    input  logic                  clock,
    input  logic                  reset,

    input  logic                  i_rd_req,
    input  logic [2:0]            i_rd_type,
    input  logic [31:0]           i_rd_addr,
    output logic                  i_rd_rdy,
    output logic                  i_ret_valid,
    output logic                  i_ret_last,
    output logic [DATA_WIDTH-1:0] i_ret_data,

    input  logic                  d_rd_req,
    input  logic [2:0]            d_rd_type,
    input  logic [31:0]           d_rd_addr,
    output logic                  d_rd_rdy,
    output logic                  d_ret_valid,
    output logic                  d_ret_last,
    output logic [DATA_WIDTH-1:0] d_ret_data,

    output logic [ID_WIDTH-1:0]   arid,
    output logic [31:0]           araddr,
    output logic [7:0]            arlen,
    output logic [2:0]            arsize,
    output logic [1:0]            arburst,
    output logic [1:0]            arlock,
    output logic [3:0]            arcache,
    output logic [2:0]            arprot,
    output logic                  arvalid,
    input  logic                  arready,

    input  logic [ID_WIDTH-1:0]   rid,
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [1:0]            rresp,
    input  logic                  rlast,
    input  logic                  rvalid,
    output logic                  rready,

    output logic                  burst_err
);

    rd_state_e   state_q, state_d;
    owner_e      owner_q, owner_d;
    logic [31:0] addr_q, addr_d;
    logic [2:0]  type_q, type_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        err_q, err_d;

    logic gnt_i;
    logic gnt_d;
    logic accept;
    logic own_i_r;
    logic own_d_r;

    // Grants are suppressed while reset is held so no rdy leaks out.
    rd_grant2 u_grant (
        .clk_i    (clock),
        .rst_i    (reset),
        .en_i     ((state_q == IDLE) && !reset),
        .i_req_i  (i_rd_req),
        .d_req_i  (d_rd_req),
        .update_i (accept),
        .i_gnt_o  (gnt_i),
        .d_gnt_o  (gnt_d)
    );

    assign i_rd_rdy = gnt_i;
    assign d_rd_rdy = gnt_d;

    assign arid    = (owner_q == OWNER_D) ? ID_WIDTH'(DATA_ID)
                                          : ID_WIDTH'(INST_ID);
    assign araddr  = addr_q;
    assign arlen   = rd_arlen(type_q);
    assign arsize  = rd_arsize(type_q);
    assign arburst = AXI_BURST_INCR;
    assign arlock  = 2'b00;
    assign arcache = 4'b0000;
    assign arprot  = 3'b000;

    assign own_i_r = (state_q == R) && (owner_q == OWNER_I);
    assign own_d_r = (state_q == R) && (owner_q == OWNER_D);

    assign i_ret_valid = own_i_r && rvalid;
    assign i_ret_last  = own_i_r && rlast;
    assign i_ret_data  = own_i_r ? rdata : '0;
    assign d_ret_valid = own_d_r && rvalid;
    assign d_ret_last  = own_d_r && rlast;
    assign d_ret_data  = own_d_r ? rdata : '0;

    assign burst_err = err_q;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        addr_d  = addr_q;
        type_d  = type_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        accept  = 1'b0;
        arvalid = 1'b0;
        rready  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (gnt_i || gnt_d) begin
                    accept  = 1'b1;
                    owner_d = gnt_d ? OWNER_D : OWNER_I;
                    addr_d  = gnt_d ? d_rd_addr : i_rd_addr;
                    type_d  = gnt_d ? d_rd_type : i_rd_type;
                    state_d = AR;
                end
            end
            AR: begin
                arvalid = 1'b1;
                if (arready) begin
                    cnt_d   = 2'd0;
                    state_d = R;
                end
            end
            R: begin
                rready = 1'b1;
                if (rvalid) begin
                    cnt_d = cnt_q + 2'd1;
                    // rlast must coincide exactly with the final beat.
                    if (rlast != (cnt_q == arlen[1:0])) begin
                        err_d = 1'b1;
                    end
                    if (rlast) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= OWNER_I;
            addr_q  <= 32'd0;
            type_q  <= RD_TYPE_BYTE;
            cnt_q   <= 2'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            addr_q  <= addr_d;
            type_q  <= type_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    logic unused_ok;
    assign unused_ok = ^{rid, rresp};

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter: AXI slave driven by hand,
// expected values computed by hand per scenario.
module tb_axi_rd_arbiter;

    logic        clock;
    logic        reset;
    logic        i_rd_req, d_rd_req;
    logic [2:0]  i_rd_type, d_rd_type;
    logic [31:0] i_rd_addr, d_rd_addr;
    logic        i_rd_rdy, d_rd_rdy;
    logic        i_ret_valid, i_ret_last, d_ret_valid, d_ret_last;
    logic [31:0] i_ret_data, d_ret_data;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst, arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid, arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast, rvalid, rready;
    logic        burst_err;

    int n_cmp = 0;
    int n_bad = 0;

    axi_rd_arbiter dut (
        .clock(clock), .reset(reset),
        .i_rd_req(i_rd_req), .i_rd_type(i_rd_type), .i_rd_addr(i_rd_addr),
        .i_rd_rdy(i_rd_rdy), .i_ret_valid(i_ret_valid),
        .i_ret_last(i_ret_last), .i_ret_data(i_ret_data),
        .d_rd_req(d_rd_req), .d_rd_type(d_rd_type), .d_rd_addr(d_rd_addr),
        .d_rd_rdy(d_rd_rdy), .d_ret_valid(d_ret_valid),
        .d_ret_last(d_ret_last), .d_ret_data(d_ret_data),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arlock(arlock), .arcache(arcache),
        .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready), .burst_err(burst_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    // Stimulus only: AR handshake then n beats, rlast on the final one.
    task automatic serve(input int n, input logic [31:0] base);
        arready = 1'b1;
        tick();
        arready = 1'b0;
        for (int b = 0; b < n; b++) begin
            rvalid = 1'b1;
            rdata  = base + 32'(b);
            rlast  = (b == n - 1);
            tick();
        end
        rvalid = 1'b0;
        rlast  = 1'b0;
    endtask

    task automatic test_reset();
        i_rd_req = 1'b1;
        d_rd_req = 1'b1;
        rvalid   = 1'b1;
        rlast    = 1'b1;
        #1;
        n_cmp++;
        if ({i_rd_rdy, d_rd_rdy, arvalid, rready} !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_ctl: got %b want 0000",
                     {i_rd_rdy, d_rd_rdy, arvalid, rready});
        end
        n_cmp++;
        if ({i_ret_valid, d_ret_valid, i_ret_last, d_ret_last, burst_err}
            !== 5'b00000) begin
            n_bad++;
            $display("FAIL reset_ret: got %b want 00000",
                     {i_ret_valid, d_ret_valid, i_ret_last, d_ret_last,
                      burst_err});
        end
        i_rd_req = 1'b0;
        d_rd_req = 1'b0;
        rvalid   = 1'b0;
        rlast    = 1'b0;
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_arbitration();
        logic exp_d;
        logic last_d;
        last_d    = 1'b0;
        i_rd_req  = 1'b1;
        d_rd_req  = 1'b1;
        i_rd_type = 3'b010;
        d_rd_type = 3'b010;
        i_rd_addr = 32'h0000_0010;
        d_rd_addr = 32'h0000_0020;
        for (int k = 0; k < 4; k++) begin
`ifdef AXI_RD_ARB_RR_EN
            exp_d = ~last_d;
`else
            exp_d = 1'b1;
`endif
            #1;
            n_cmp++;
            if ({d_rd_rdy, i_rd_rdy} !== {exp_d, ~exp_d}) begin
                n_bad++;
                $display("FAIL arb_rdy[%0d]: got d=%b i=%b want d=%b i=%b",
                         k, d_rd_rdy, i_rd_rdy, exp_d, ~exp_d);
            end
            tick();
            #1;
            n_cmp++;
            if ({arvalid, arid, araddr} !==
                {1'b1, (exp_d ? 4'd1 : 4'd0),
                 (exp_d ? 32'h20 : 32'h10)}) begin
                n_bad++;
                $display("FAIL arb_ar[%0d]: got v=%b id=%h a=%h want d=%b",
                         k, arvalid, arid, araddr, exp_d);
            end
            last_d = exp_d;
            serve(1, 32'h100 + 32'(k));
        end
        i_rd_req = 1'b0;
        d_rd_req = 1'b0;
    endtask

    task automatic test_line_i();
        i_rd_req  = 1'b1;
        i_rd_type = 3'b100;
        i_rd_addr = 32'h0000_0100;
        #1;
        n_cmp++;
        if ({i_rd_rdy, d_rd_rdy} !== 2'b10) begin
            n_bad++;
            $display("FAIL line_rdy: got %b want 10", {i_rd_rdy, d_rd_rdy});
        end
        tick();
        i_rd_req = 1'b0;
        #1;
        n_cmp++;
        if ({arvalid, arid, araddr, arlen, arsize} !==
            {1'b1, 4'd0, 32'h100, 8'd3, 3'd2}) begin
            n_bad++;
            $display("FAIL line_ar: got v=%b id=%h a=%h len=%0d sz=%0d",
                     arvalid, arid, araddr, arlen, arsize);
        end
        arready = 1'b1;
        tick();
        arready = 1'b0;
        for (int b = 0; b < 4; b++) begin
            rvalid = 1'b1;
            rdata  = 32'hA0 + 32'(b);
            rlast  = (b == 3);
            #1;
            n_cmp++;
            if ({rready, i_ret_valid, i_ret_last, d_ret_valid, i_ret_data}
                !== {1'b1, 1'b1, (b == 3), 1'b0, 32'hA0 + 32'(b)}) begin
                n_bad++;
                $display("FAIL line_beat[%0d]: got rr=%b v=%b l=%b dv=%b d=%h",
                         b, rready, i_ret_valid, i_ret_last, d_ret_valid,
                         i_ret_data);
            end
            tick();
        end
        rvalid = 1'b0;
        rlast  = 1'b0;
        #1;
        n_cmp++;
        if ({arvalid, rready, burst_err} !== 3'b000) begin
            n_bad++;
            $display("FAIL line_end: got %b want 000",
                     {arvalid, rready, burst_err});
        end
    endtask

    task automatic test_byte_d();
        d_rd_req  = 1'b1;
        d_rd_type = 3'b000;
        d_rd_addr = 32'h0000_0203;
        #1;
        n_cmp++;
        if (d_rd_rdy !== 1'b1) begin
            n_bad++;
            $display("FAIL byte_rdy: got %b want 1", d_rd_rdy);
        end
        tick();
        d_rd_req = 1'b0;
        #1;
        n_cmp++;
        if ({arid, araddr, arlen, arsize} !== {4'd1, 32'h203, 8'd0, 3'd0}) begin
            n_bad++;
            $display("FAIL byte_ar: got id=%h a=%h len=%0d sz=%0d",
                     arid, araddr, arlen, arsize);
        end
        n_cmp++;
        if ({arburst, arlock, arcache, arprot} !== 11'b01_00_0000_000) begin
            n_bad++;
            $display("FAIL byte_fixed: got %b want 01000000000",
                     {arburst, arlock, arcache, arprot});
        end
        arready = 1'b1;
        tick();
        arready = 1'b0;
        rvalid  = 1'b1;
        rdata   = 32'h0000_005A;
        rlast   = 1'b1;
        #1;
        n_cmp++;
        if ({d_ret_valid, d_ret_last, i_ret_valid, d_ret_data} !==
            {3'b110, 32'h5A}) begin
            n_bad++;
            $display("FAIL byte_beat: got dv=%b dl=%b iv=%b d=%h",
                     d_ret_valid, d_ret_last, i_ret_valid, d_ret_data);
        end
        tick();
        rvalid = 1'b0;
        rlast  = 1'b0;
    endtask

    task automatic test_type_map();
        logic [2:0] tt[5];
        logic [2:0] sz[5];
        tt = '{3'b001, 3'b011, 3'b101, 3'b111, 3'b010};
        sz = '{3'd1, 3'd2, 3'd2, 3'd2, 3'd2};
        for (int k = 0; k < 5; k++) begin
            i_rd_req  = 1'b1;
            i_rd_type = tt[k];
            i_rd_addr = 32'h40 + 32'(4 * k);
            tick();
            i_rd_req = 1'b0;
            #1;
            n_cmp++;
            if ({arlen, arsize} !== {8'd0, sz[k]}) begin
                n_bad++;
                $display("FAIL type_map[%b]: got len=%0d sz=%0d want 0/%0d",
                         tt[k], arlen, arsize, sz[k]);
            end
            serve(1, 32'h0);
        end
    endtask

    task automatic test_ar_stall();
        i_rd_req  = 1'b1;
        i_rd_type = 3'b010;
        i_rd_addr = 32'h0000_0044;
        tick();
        d_rd_req  = 1'b1;
        d_rd_type = 3'b010;
        d_rd_addr = 32'h0000_0088;
        for (int c = 0; c < 5; c++) begin
            #1;
            n_cmp++;
            if ({arvalid, arid, araddr, arlen, arsize, i_rd_rdy, d_rd_rdy}
                !== {1'b1, 4'd0, 32'h44, 8'd0, 3'd2, 2'b00}) begin
                n_bad++;
                $display("FAIL stall[%0d]: got v=%b id=%h a=%h ir=%b dr=%b",
                         c, arvalid, arid, araddr, i_rd_rdy, d_rd_rdy);
            end
            tick();
        end
        arready = 1'b1;
        tick();
        arready = 1'b0;
        #1;
        n_cmp++;
        if ({rready, arvalid, i_rd_rdy, d_rd_rdy} !== 4'b1000) begin
            n_bad++;
            $display("FAIL stall_r: got %b want 1000",
                     {rready, arvalid, i_rd_rdy, d_rd_rdy});
        end
        tick();
        rvalid = 1'b1;
        rlast  = 1'b1;
        rdata  = 32'hCAFE_0044;
        #1;
        n_cmp++;
        if ({i_ret_valid, i_ret_last, i_rd_rdy, d_rd_rdy, i_ret_data} !==
            {4'b1100, 32'hCAFE_0044}) begin
            n_bad++;
            $display("FAIL stall_beat: got v=%b l=%b ir=%b dr=%b d=%h",
                     i_ret_valid, i_ret_last, i_rd_rdy, d_rd_rdy, i_ret_data);
        end
        i_rd_req = 1'b0;
        d_rd_req = 1'b0;
        tick();
        rvalid = 1'b0;
        rlast  = 1'b0;
    endtask

    task automatic test_burst_err();
        i_rd_req  = 1'b1;
        i_rd_type = 3'b100;
        i_rd_addr = 32'h0000_0180;
        tick();
        i_rd_req = 1'b0;
        arready  = 1'b1;
        tick();
        arready = 1'b0;
        rvalid  = 1'b1;
        rlast   = 1'b0;
        rdata   = 32'h11;
        tick();
        rlast = 1'b1;
        rdata = 32'h22;
        #1;
        n_cmp++;
        if ({burst_err, i_ret_valid, i_ret_last} !== 3'b011) begin
            n_bad++;
            $display("FAIL err_pre: got %b want 011",
                     {burst_err, i_ret_valid, i_ret_last});
        end
        tick();
        rvalid = 1'b0;
        rlast  = 1'b0;
        #1;
        n_cmp++;
        if ({burst_err, arvalid, rready} !== 3'b100) begin
            n_bad++;
            $display("FAIL err_set: got %b want 100",
                     {burst_err, arvalid, rready});
        end
        d_rd_req  = 1'b1;
        d_rd_type = 3'b010;
        d_rd_addr = 32'h0000_0400;
        #1;
        n_cmp++;
        if (d_rd_rdy !== 1'b1) begin
            n_bad++;
            $display("FAIL err_next_rdy: got %b want 1", d_rd_rdy);
        end
        tick();
        d_rd_req = 1'b0;
        #1;
        n_cmp++;
        if ({arid, araddr, arlen} !== {4'd1, 32'h400, 8'd0}) begin
            n_bad++;
            $display("FAIL err_next_ar: got id=%h a=%h len=%0d",
                     arid, araddr, arlen);
        end
        arready = 1'b1;
        tick();
        arready = 1'b0;
        rvalid  = 1'b1;
        rlast   = 1'b1;
        rdata   = 32'h33;
        #1;
        n_cmp++;
        if ({d_ret_valid, d_ret_last, d_ret_data} !== {2'b11, 32'h33}) begin
            n_bad++;
            $display("FAIL err_next_beat: got v=%b l=%b d=%h",
                     d_ret_valid, d_ret_last, d_ret_data);
        end
        tick();
        rvalid = 1'b0;
        rlast  = 1'b0;
        #1;
        n_cmp++;
        if ({burst_err, rready} !== 2'b10) begin
            n_bad++;
            $display("FAIL err_sticky: got %b want 10", {burst_err, rready});
        end
    endtask

    task automatic test_reset_mid();
        i_rd_req  = 1'b1;
        i_rd_type = 3'b100;
        i_rd_addr = 32'h0000_0500;
        tick();
        i_rd_req = 1'b0;
        serve(0, 32'h0);
        rvalid = 1'b1;
        rlast  = 1'b0;
        rdata  = 32'h55;
        tick();
        rdata = 32'h56;
        #1;
        n_cmp++;
        if ({rready, i_ret_valid} !== 2'b11) begin
            n_bad++;
            $display("FAIL rst_mid_pre: got %b want 11", {rready, i_ret_valid});
        end
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({arvalid, rready, i_ret_valid, d_ret_valid, burst_err}
            !== 5'b00000) begin
            n_bad++;
            $display("FAIL rst_mid: got %b want 00000",
                     {arvalid, rready, i_ret_valid, d_ret_valid, burst_err});
        end
        rvalid = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        d_rd_req  = 1'b1;
        d_rd_type = 3'b010;
        d_rd_addr = 32'h0000_0600;
        #1;
        n_cmp++;
        if ({d_rd_rdy, i_rd_rdy} !== 2'b10) begin
            n_bad++;
            $display("FAIL rst_after_rdy: got %b want 10", {d_rd_rdy, i_rd_rdy});
        end
        tick();
        d_rd_req = 1'b0;
        #1;
        n_cmp++;
        if ({arvalid, arid, araddr} !== {1'b1, 4'd1, 32'h600}) begin
            n_bad++;
            $display("FAIL rst_after_ar: got v=%b id=%h a=%h",
                     arvalid, arid, araddr);
        end
        arready = 1'b1;
        tick();
        arready = 1'b0;
        rvalid  = 1'b1;
        rlast   = 1'b1;
        rdata   = 32'h66;
        #1;
        n_cmp++;
        if ({d_ret_valid, d_ret_last, i_ret_valid, d_ret_data} !==
            {3'b110, 32'h66}) begin
            n_bad++;
            $display("FAIL rst_after_beat: got dv=%b dl=%b iv=%b d=%h",
                     d_ret_valid, d_ret_last, i_ret_valid, d_ret_data);
        end
        tick();
        rvalid = 1'b0;
        rlast  = 1'b0;
        #1;
        n_cmp++;
        if ({arvalid, rready, burst_err} !== 3'b000) begin
            n_bad++;
            $display("FAIL rst_after_end: got %b want 000",
                     {arvalid, rready, burst_err});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        i_rd_req  = 1'b0;
        d_rd_req  = 1'b0;
        i_rd_type = 3'b000;
        d_rd_type = 3'b000;
        i_rd_addr = 32'h0;
        d_rd_addr = 32'h0;
        arready   = 1'b0;
        rid       = 4'h0;
        rdata     = 32'h0;
        rresp     = 2'b00;
        rlast     = 1'b0;
        rvalid    = 1'b0;
        repeat (2) @(negedge clock);
        test_reset();
        test_arbitration();
        test_line_i();
        test_byte_d();
        test_type_map();
        test_ar_stall();
        test_burst_err();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
